// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/load-store memory arbiter: response-owner
// encoding and the default starvation limit.
package mem_arbiter_pkg;

   localparam int DEF_STARVE_LIM = 4;
   localparam int DW             = 32;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_LOAD  = 2'd2
   } owner_e;

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating count of consecutive denied fetch cycles; at_limit forces a fetch win.
// Clear has priority over wait so a grant and a fresh request restart from zero.
module starve_counter #(
   parameter int LIM = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_wait,
   input  logic i_clear,
   output logic o_at_limit
);

   localparam int CW = (LIM < 1) ? 1 : $clog2(LIM + 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_wait && (r_cnt != CW'(LIM))) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_at_limit = (r_cnt == CW'(LIM));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch, load/store) arbiter onto a single-port memory with one-cycle
// read latency; loads win unless the fetch port has been starved STARVE_LIM cycles.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIM = DEF_STARVE_LIM,
   parameter int AW         = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_gnt,
   output logic          i_rvalid,
   output logic [DW-1:0] i_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          m_en,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata
);

   logic   w_at_limit;
   logic   w_i_win;
   logic   w_d_win;
   logic   w_wait;
   owner_e r_owner;
   owner_e w_owner_nxt;

   // Grants are gated by reset so nothing reaches the memory while it is held.
   assign w_i_win = ~reset & i_req & (w_at_limit | ~d_req);
   assign w_d_win = ~reset & d_req & ~w_i_win;
   assign w_wait  = i_req & ~w_i_win;

   starve_counter #(.LIM(STARVE_LIM)) u_starve (
      .clk       (clk),
      .reset     (reset),
      .i_wait    (w_wait),
      .i_clear   (~w_wait),
      .o_at_limit(w_at_limit)
   );

   always_comb begin
      i_gnt   = w_i_win;
      d_gnt   = w_d_win;
      m_en    = 1'b0;
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      if (w_i_win) begin
         m_en   = 1'b1;
         m_addr = i_addr;
      end else if (w_d_win) begin
         m_en    = 1'b1;
         m_we    = d_we;
         m_addr  = d_addr;
         m_wdata = d_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_owner <= OWN_NONE;
      end else begin
         r_owner <= w_owner_nxt;
      end
   end

   always_comb begin
      w_owner_nxt = OWN_NONE;
      if (w_i_win) begin
         w_owner_nxt = OWN_FETCH;
      end else if (w_d_win && !d_we) begin
         w_owner_nxt = OWN_LOAD;
      end
   end

   always_comb begin
      i_rvalid = (r_owner == OWN_FETCH);
      d_rvalid = (r_owner == OWN_LOAD);
      i_rdata  = m_rdata;
      d_rdata  = m_rdata;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed checks of mem_arbiter against a behavioural single-port memory.
module tb_mem_arbiter;

   logic        clk;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        m_en;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;

   logic [31:0] mem [0:255];
   int n_tests;
   int n_fail;

   mem_arbiter #(.STARVE_LIM(4), .AW(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .i_req   (i_req),
      .i_addr  (i_addr),
      .i_gnt   (i_gnt),
      .i_rvalid(i_rvalid),
      .i_rdata (i_rdata),
      .d_req   (d_req),
      .d_we    (d_we),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_gnt   (d_gnt),
      .d_rvalid(d_rvalid),
      .d_rdata (d_rdata),
      .m_en    (m_en),
      .m_we    (m_we),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_rdata (m_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (m_en) begin
         if (m_we) mem[m_addr[9:2]] <= m_wdata;
         else      m_rdata <= mem[m_addr[9:2]];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_gnt"},    {30'd0, i_gnt, d_gnt}, 32'd0);
      check({tag, "_rvalid"}, {30'd0, i_rvalid, d_rvalid}, 32'd0);
      check({tag, "_men"},    {30'd0, m_en, m_we}, 32'd0);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h04] = 32'h00A00093;   // 0x010
      mem[8'h40] = 32'h12345678;   // 0x100
      m_rdata = 32'h0;
      reset = 1'b1;
      i_req = 1'b0; i_addr = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;

      // Reset: everything quiet even with both ports requesting
      tick();
      tick();
      i_req = 1'b1; d_req = 1'b1; i_addr = 32'h10; d_addr = 32'h100;
      #1;
      check_all_zero("rst");
      tick();
      check_all_zero("rst2");

      // Fetch only, granted in the first cycle after reset release
      reset = 1'b0; d_req = 1'b0;
      #1;
      check("f_igt",  {31'd0, i_gnt}, 32'd1);
      check("f_dgt",  {31'd0, d_gnt}, 32'd0);
      check("f_maddr", m_addr, 32'h10);
      check("f_mwe",  {31'd0, m_we}, 32'd0);
      tick();
      i_req = 1'b0;
      #1;
      check("f_irv",  {31'd0, i_rvalid}, 32'd1);
      check("f_ird",  i_rdata, 32'h00A00093);
      check("f_drv",  {31'd0, d_rvalid}, 32'd0);

      // Contention: load wins, fetch follows
      tick();
      i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
      #1;
      check("c_dgt",  {31'd0, d_gnt}, 32'd1);
      check("c_igt",  {31'd0, i_gnt}, 32'd0);
      check("c_maddr", m_addr, 32'h100);
      tick();
      d_req = 1'b0;
      #1;
      check("c_drv",  {31'd0, d_rvalid}, 32'd1);
      check("c_drd",  d_rdata, 32'h12345678);
      check("c_irv0", {31'd0, i_rvalid}, 32'd0);
      check("c_igt2", {31'd0, i_gnt}, 32'd1);
      tick();
      i_req = 1'b0;
      #1;
      check("c_irv",  {31'd0, i_rvalid}, 32'd1);

      // Starvation: loads for 4 cycles, forced fetch in cycle 4, load again in 5
      for (int c = 0; c < 6; c++) begin
         tick();
         i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
         #1;
         check($sformatf("s_igt%0d", c), {31'd0, i_gnt}, {31'd0, c == 4});
         check($sformatf("s_dgt%0d", c), {31'd0, d_gnt}, {31'd0, c != 4});
         check($sformatf("s_irv%0d", c), {31'd0, i_rvalid}, {31'd0, c == 5});
         check($sformatf("s_drv%0d", c), {31'd0, d_rvalid}, {31'd0, (c >= 1) && (c != 5)});
      end
      tick();
      d_req = 1'b0;
      #1;
      check("s_igt6", {31'd0, i_gnt}, 32'd1);
      check("s_drv6", {31'd0, d_rvalid}, 32'd1);
      tick();
      i_req = 1'b0;
      #1;
      check("s_irv7", {31'd0, i_rvalid}, 32'd1);

      // Store then load the same word
      tick();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
      #1;
      check("st_dgt",  {31'd0, d_gnt}, 32'd1);
      check("st_mwe",  {31'd0, m_we}, 32'd1);
      check("st_mwd",  m_wdata, 32'hDEADBEEF);
      check("st_maddr", m_addr, 32'h200);
      tick();
      d_we = 1'b0;
      #1;
      check("st_drv",  {31'd0, d_rvalid}, 32'd0);
      check("ld_dgt",  {31'd0, d_gnt}, 32'd1);
      check("ld_mwe",  {31'd0, m_we}, 32'd0);
      tick();
      d_req = 1'b0;
      #1;
      check("ld_drv",  {31'd0, d_rvalid}, 32'd1);
      check("ld_drd",  d_rdata, 32'hDEADBEEF);
      check("ld_idle", {31'd0, m_en}, 32'd0);

      // Alternating fetch / load each cycle
      for (int k = 0; k < 6; k++) begin
         tick();
         i_req = (k % 2 == 0); i_addr = 32'h10;
         d_req = (k % 2 != 0); d_we = 1'b0; d_addr = 32'h100;
         #1;
         check($sformatf("a_gnt%0d", k), {30'd0, i_gnt, d_gnt}, (k % 2 == 0) ? 32'd2 : 32'd1);
         check($sformatf("a_irv%0d", k), {31'd0, i_rvalid}, {31'd0, k % 2 == 1});
         check($sformatf("a_drv%0d", k), {31'd0, d_rvalid}, {31'd0, (k > 0) && (k % 2 == 0)});
         if (k > 0)
            check($sformatf("a_rd%0d", k), (k % 2 == 1) ? i_rdata : d_rdata,
                  (k % 2 == 1) ? 32'h00A00093 : 32'h12345678);
      end
      tick();
      i_req = 1'b0; d_req = 1'b0;
      #1;
      check("a_drv6", {31'd0, d_rvalid}, 32'd1);
      check("a_irv6", {31'd0, i_rvalid}, 32'd0);

      // Reset over the response cycle discards the pending fetch data
      tick();
      i_req = 1'b1; i_addr = 32'h10;
      #1;
      check("r_igt", {31'd0, i_gnt}, 32'd1);
      @(posedge clk);
      reset = 1'b1; i_req = 1'b0;
      #1;
      check_all_zero("rm");
      tick();
      reset = 1'b0;
      #1;
      check("r_irv1", {31'd0, i_rvalid}, 32'd0);
      tick();
      #1;
      check("r_irv2", {31'd0, i_rvalid}, 32'd0);
      check("r_drv2", {31'd0, d_rvalid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
